// File: rtl/np_fm_pkg.sv
// Shared feature-map constants and FSM encodings, also consumed by the read controller.
package np_fm_pkg;

    localparam int NP_NUM_BANKS  = 8;
    localparam int NP_DEPTH      = 256;
    localparam int NP_ADDR_MAX   = NP_DEPTH - 1;
    localparam int NP_ADDR_WIDTH = 8;
    localparam int NP_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fm_wr_state_e;

    function automatic int bank_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/np_bank_addr_counter.sv
// Bank/address sweep counter. FM_WR_BANK_INTERLEAVE_EN selects word-interleaved
// order (bank carries into addr); default is bank-major (addr carries into bank).
module np_bank_addr_counter #(
    parameter int NUM_BANKS  = 8,
    parameter int ADDR_MAX   = 255,
    parameter int ADDR_WIDTH = 8,
    parameter int BANK_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_inc,
    input  logic                  i_clr,
    output logic [BANK_WIDTH-1:0] o_bank,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);

    logic [BANK_WIDTH-1:0] r_bank;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  w_bank_end;
    logic                  w_addr_end;

    // Explicit end compares (not overflow) so non-power-of-2 sizes wrap correctly.
    assign w_bank_end = (r_bank == BANK_WIDTH'(NUM_BANKS - 1));
    assign w_addr_end = (r_addr == ADDR_WIDTH'(ADDR_MAX));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_bank <= '0;
            r_addr <= '0;
        end else if (i_clr) begin
            r_bank <= '0;
            r_addr <= '0;
        end else if (i_inc) begin
`ifdef FM_WR_BANK_INTERLEAVE_EN
            if (w_bank_end) begin
                r_bank <= '0;
                r_addr <= w_addr_end ? '0 : r_addr + ADDR_WIDTH'(1);
            end else begin
                r_bank <= r_bank + BANK_WIDTH'(1);
            end
`else
            if (w_addr_end) begin
                r_addr <= '0;
                r_bank <= w_bank_end ? '0 : r_bank + BANK_WIDTH'(1);
            end else begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
            end
`endif
        end
    end

    assign o_bank = r_bank;
    assign o_addr = r_addr;
    assign o_last = w_bank_end && w_addr_end;

endmodule

// File: rtl/np_fm_write_ctrl.sv
// Feature-map write controller: streams words into NUM_BANKS RAMs in reader order,
// then pulses start_mult. Order set by FM_WR_BANK_INTERLEAVE_EN (see counter).
module np_fm_write_ctrl
    import np_fm_pkg::*;
#(
    parameter int NUM_BANKS  = NP_NUM_BANKS,
    parameter int DEPTH      = NP_DEPTH,
    parameter int ADDR_WIDTH = NP_ADDR_WIDTH,
    parameter int DATA_WIDTH = NP_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_load_req,
    input  logic                  i_in_valid,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    output logic                  o_in_ready,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic [NUM_BANKS-1:0]  o_wr_en,
    output logic                  o_busy,
    output logic                  o_fill_done,
    output logic                  o_start_mult
);

    localparam int ADDR_MAX   = DEPTH - 1;
    localparam int BANK_WIDTH = bank_width(NUM_BANKS);

    fm_wr_state_e          r_state;
    fm_wr_state_e          w_next;
    logic [BANK_WIDTH-1:0] w_bank;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_last;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_clr;
    logic [NUM_BANKS-1:0]  w_bank_sel;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [NUM_BANKS-1:0]  r_wr_en;
    logic                  r_done;

    assign w_in_ready = (r_state == ST_FILL) && !i_load_req;
    assign w_accept   = i_in_valid && w_in_ready;
    // load_req restarts from IDLE or mid-fill; it is ignored in DONE.
    assign w_clr      = i_load_req && (r_state != ST_DONE);

    np_bank_addr_counter #(
        .NUM_BANKS  (NUM_BANKS),
        .ADDR_MAX   (ADDR_MAX),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BANK_WIDTH (BANK_WIDTH)
    ) u_cnt (
        .clock  (clock),
        .reset  (reset),
        .i_inc  (w_accept),
        .i_clr  (w_clr),
        .o_bank (w_bank),
        .o_addr (w_addr),
        .o_last (w_last)
    );

    always_comb begin
        w_bank_sel         = '0;
        w_bank_sel[w_bank] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_load_req) w_next = ST_FILL;
            ST_FILL: if (w_accept && w_last) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Pulses are registered off the last acceptance so they coincide with the last write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_en   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_wr_en <= w_accept ? w_bank_sel : '0;
            r_done  <= w_accept && w_last;
            if (w_accept) begin
                r_wr_addr <= w_addr;
                r_wr_data <= i_in_data;
            end
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_wr_en      = r_wr_en;
    assign o_busy       = (r_state == ST_FILL);
    assign o_fill_done  = r_done;
    assign o_start_mult = r_done;

endmodule

// File: tb/tb_np_fm_write_ctrl.sv
// Directed bench for np_fm_write_ctrl (NUM_BANKS=2, DEPTH=4); honours FM_WR_BANK_INTERLEAVE_EN.
module tb_np_fm_write_ctrl;

    localparam int NB = 2;
    localparam int DP = 4;
    localparam int AW = 2;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          load_req = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [NB-1:0] wr_en;
    logic          busy;
    logic          fill_done;
    logic          start_mult;

    int   n_checks = 0;
    int   n_errors = 0;
    logic rdy_pre;
    logic [DW-1:0] mem [NB][DP];

    np_fm_write_ctrl #(.NUM_BANKS(NB), .DEPTH(DP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .i_load_req   (load_req),
        .i_in_valid   (in_valid),
        .i_in_data    (in_data),
        .o_in_ready   (in_ready),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_wr_en      (wr_en),
        .o_busy       (busy),
        .o_fill_done  (fill_done),
        .o_start_mult (start_mult)
    );

    always #5 clock = ~clock;

    // RAM model: each bank commits on the edge where its write enable is high.
    always @(posedge clock) begin
        for (int b = 0; b < NB; b++)
            if (wr_en[b]) mem[b][wr_addr] <= wr_data;
    end

    typedef struct {
        logic          lr;
        logic          vld;
        logic [DW-1:0] din;
        logic          rdy;
        logic [NB-1:0] wen;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          bsy;
        logic          pulse;
    } vec_t;

    vec_t tbl [11];

    // Word index w -> bank/addr in the reader's sweep order.
    function automatic int exp_bank(input int w);
`ifdef FM_WR_BANK_INTERLEAVE_EN
        return w % NB;
`else
        return w / DP;
`endif
    endfunction

    function automatic int exp_addr(input int w);
`ifdef FM_WR_BANK_INTERLEAVE_EN
        return w / NB;
`else
        return w % DP;
`endif
    endfunction

    function automatic int word_idx(input int b, input int a);
`ifdef FM_WR_BANK_INTERLEAVE_EN
        return a * NB + b;
`else
        return b * DP + a;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic lr, input logic v, input logic [DW-1:0] d);
        @(negedge clock);
        load_req = lr;
        in_valid = v;
        in_data  = d;
        #1 rdy_pre = in_ready;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_wr(input string tag, input int w, input logic [DW-1:0] d, input logic last);
        chk({tag, " rdy"},   32'(rdy_pre), 32'd1);
        chk({tag, " wr_en"}, 32'(wr_en), 32'(1 << exp_bank(w)));
        chk({tag, " addr"},  32'(wr_addr), 32'(exp_addr(w)));
        chk({tag, " data"},  32'(wr_data), 32'(d));
        chk({tag, " done"},  32'(fill_done), 32'(last));
        chk({tag, " start"}, 32'(start_mult), 32'(last));
        chk({tag, " busy"},  32'(busy), 32'(!last));
    endtask

    task automatic chk_mem(input string tag, input logic [DW-1:0] base);
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DP; a++)
                chk($sformatf("%s mem[%0d][%0d]", tag, b, a), 32'(mem[b][a]), 32'(base + DW'(word_idx(b, a))));
    endtask

    initial begin
        // Full-fill vectors: expectations are outputs after the edge consuming the inputs.
        tbl[0] = '{lr:1'b1, vld:1'b0, din:16'h0, rdy:1'b0, wen:'0, waddr:'0, wdata:16'h0, bsy:1'b1, pulse:1'b0};
        for (int w = 0; w < 8; w++)
            tbl[w+1] = '{lr:1'b0, vld:1'b1, din:16'h10 + 16'(w), rdy:1'b1, wen:NB'(1 << exp_bank(w)),
                         waddr:AW'(exp_addr(w)), wdata:16'h10 + 16'(w), bsy:(w != 7), pulse:(w == 7)};
        tbl[9]  = '{lr:1'b0, vld:1'b1, din:16'h55, rdy:1'b0, wen:'0, waddr:2'd3, wdata:16'h17, bsy:1'b0, pulse:1'b0};
        tbl[10] = '{lr:1'b0, vld:1'b1, din:16'h66, rdy:1'b0, wen:'0, waddr:2'd3, wdata:16'h17, bsy:1'b0, pulse:1'b0};

        // Reset state
        #12;
        chk("rst in_ready", 32'(in_ready), 0);
        chk("rst wr_en", 32'(wr_en), 0);
        chk("rst wr_addr", 32'(wr_addr), 0);
        chk("rst wr_data", 32'(wr_data), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst pulses", 32'({fill_done, start_mult}), 0);
        @(negedge clock) reset = 1'b1;

        // Full fill, table-driven
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].lr, tbl[i].vld, tbl[i].din);
            chk($sformatf("v%0d in_ready", i), 32'(rdy_pre), 32'(tbl[i].rdy));
            chk($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(tbl[i].wen));
            chk($sformatf("v%0d wr_addr", i), 32'(wr_addr), 32'(tbl[i].waddr));
            chk($sformatf("v%0d wr_data", i), 32'(wr_data), 32'(tbl[i].wdata));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("v%0d fill_done", i), 32'(fill_done), 32'(tbl[i].pulse));
            chk($sformatf("v%0d start_mult", i), 32'(start_mult), 32'(tbl[i].pulse));
        end
        chk_mem("full", 16'h10);

        // Idle guard: valid with no load_req never writes
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, 16'hEE);
            chk($sformatf("idle%0d rdy", i), 32'(rdy_pre), 0);
            chk($sformatf("idle%0d wr_en", i), 32'(wr_en), 0);
        end

        // Stalls: valid pattern 1,0,0,1,0,0,... ; then load_req in DONE is ignored
        begin
            int pulses = 0;
            int writes = 0;
            cyc(1'b1, 1'b0, 16'h0);
            for (int w = 0; w < 8; w++) begin
                cyc(1'b0, 1'b1, 16'h30 + 16'(w));
                chk_wr($sformatf("stall w%0d", w), w, 16'h30 + 16'(w), w == 7);
                pulses += int'(start_mult);
                writes += (wr_en != 0) ? 1 : 0;
                if (w < 7)
                    for (int s = 0; s < 2; s++) begin
                        cyc(1'b0, 1'b0, 16'hDEAD);
                        chk($sformatf("stall w%0d s%0d rdy", w, s), 32'(rdy_pre), 1);
                        chk($sformatf("stall w%0d s%0d wr_en", w, s), 32'(wr_en), 0);
                        pulses += int'(start_mult);
                        writes += (wr_en != 0) ? 1 : 0;
                    end
            end
            cyc(1'b1, 1'b1, 16'h77);
            chk("done-lr rdy", 32'(rdy_pre), 0);
            chk("done-lr busy", 32'(busy), 0);
            chk("done-lr wr_en", 32'(wr_en), 0);
            pulses += int'(start_mult);
            cyc(1'b0, 1'b1, 16'h78);
            chk("done-lr idle rdy", 32'(rdy_pre), 0);
            chk("done-lr idle busy", 32'(busy), 0);
            pulses += int'(start_mult);
            chk("stall start count", 32'(pulses), 1);
            chk("stall write count", 32'(writes), 8);
            chk_mem("stall", 16'h30);
        end

        // Restart after 3 words
        cyc(1'b1, 1'b0, 16'h0);
        for (int w = 0; w < 3; w++) begin
            cyc(1'b0, 1'b1, 16'h50 + 16'(w));
            chk_wr($sformatf("pre-rst w%0d", w), w, 16'h50 + 16'(w), 1'b0);
        end
        cyc(1'b1, 1'b1, 16'h99);
        chk("restart rdy", 32'(rdy_pre), 0);
        chk("restart wr_en", 32'(wr_en), 0);
        chk("restart busy", 32'(busy), 1);
        for (int w = 0; w < 8; w++) begin
            cyc(1'b0, 1'b1, 16'hAA + 16'(w));
            chk_wr($sformatf("restart w%0d", w), w, 16'hAA + 16'(w), w == 7);
        end
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);
        chk_mem("restart", 16'hAA);

        // Reset mid-fill after 5 words
        cyc(1'b1, 1'b0, 16'h0);
        for (int w = 0; w < 5; w++) cyc(1'b0, 1'b1, 16'h70 + 16'(w));
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midrst in_ready", 32'(in_ready), 0);
        chk("midrst wr_en", 32'(wr_en), 0);
        chk("midrst wr_addr", 32'(wr_addr), 0);
        chk("midrst wr_data", 32'(wr_data), 0);
        chk("midrst busy", 32'(busy), 0);
        chk("midrst pulses", 32'({fill_done, start_mult}), 0);
        @(negedge clock) reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 16'h7F);
            chk($sformatf("postrst%0d wr_en", i), 32'(wr_en), 0);
            chk($sformatf("postrst%0d start", i), 32'(start_mult), 0);
        end
        cyc(1'b1, 1'b0, 16'h0);
        for (int w = 0; w < 8; w++) begin
            cyc(1'b0, 1'b1, 16'hC0 + 16'(w));
            chk_wr($sformatf("refill w%0d", w), w, 16'hC0 + 16'(w), w == 7);
        end
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);
        chk_mem("refill", 16'hC0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
